button_inputs: RTL
==================

// Module: button_inputs
// PURPOSE
//  Memory-mapped input peripheral: the read-side counterpart of the LED output port.
//  Samples WIDTH external push-buttons or switches, then synchronises, debounces and edge-detects them.
//  Exposes level, rise/fall pending and IRQ-enable registers on the simple read/write peripheral bus.
//  Sits beside the LED block on the peripheral bus and drives one level interrupt to the core.
// PARAMETERS
//  WIDTH            8       number of button inputs, 1..16
//  DEBOUNCE_CYCLES  250000  consecutive stable samples required to accept a change, >=2
//  ACTIVE_LOW       1       1: a pad at 0 means pressed; inverted at the pin before synchronisation
// PORTS
//  clk         in   1      system clock; all state on rising edge
//  reset       in   1      asynchronous, active-low reset
//  read        in   1      bus read strobe, single cycle
//  write       in   1      bus write strobe, single cycle
//  address     in   32     byte address; only address[3:2] decoded
//  write_data  in   32     write payload
//  read_data   out  32     read payload (combinational)
//  response    out  1      read | write (combinational, zero wait states)
//  buttons_in  in   WIDTH  raw asynchronous pad inputs
//  irq         out  1      level interrupt request
// BEHAVIOUR
//  Register map (address[3:2]), unused upper bits read 0:
//   0 STATE   RO  [WIDTH-1:0] debounced level, 1 = pressed
//   1 RISE    W1C [WIDTH-1:0] press-event pending
//   2 FALL    W1C [WIDTH-1:0] release-event pending
//   3 IRQ_EN  RW  [WIDTH-1:0] rise enables, [16+WIDTH-1:16] fall enables
//  - Writes to STATE are ignored.
//  - read_data = selected register when read=1, else 32'h0.
//  - Reset (async assert, sync-released by system):
//     - sync FFs, stable, counters, RISE, FALL and IRQ_EN all clear to 0.
//     - Resulting outputs: irq=0, read_data=0.
//  - Per bit pipeline: pin -> optional invert -> 2-FF synchroniser -> debounce cell.
//  - Debounce cell:
//     - cnt counts while sync != stable.
//     - cnt clears to 0 on any cycle where sync == stable.
//     - When sync != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync and cnt <= 0.
//  - Latency: a clean input change appears in STATE exactly 2 + DEBOUNCE_CYCLES clocks after the pin changes.
//     - A glitch shorter than DEBOUNCE_CYCLES samples never reaches STATE.
//  - Edge events: on the same edge stable goes 0->1, set RISE[i]; on 1->0, set FALL[i].
//     - Pending bits stay set until cleared by a write.
//  - W1C: a write with write_data[i]=1 clears the pending bit.
//     - If a set event and a clear hit the same bit in the same cycle, the set wins.
//  - irq = |(RISE & IRQ_EN[WIDTH-1:0]) | |(FALL & IRQ_EN[16+WIDTH-1:16]).
//     - Combinational from registers: asserts the cycle after the pending bit sets.
//     - Enabling an already-pending bit asserts irq on the cycle after the IRQ_EN write.
//  - Counter width = $clog2(DEBOUNCE_CYCLES); no wrap is possible because cnt clears at terminal count.
//  - Reset asserted mid-debounce: the partial count is discarded and the cell restarts from stable=0.
//  - A button held through reset release is reported as a RISE after 2 + DEBOUNCE_CYCLES clocks.
// STRUCTURE
//  - Shared peripheral package/include:
//     - register offsets BTN_STATE=0, BTN_RISE=1, BTN_FALL=2, BTN_IRQ_EN=3
//     - IRQ_EN fall-field base = 16
//  - Sub-module button_debounce: one bit, holding the synchroniser, counter and stable flop.
//     - Outputs: stable, rise_pulse, fall_pulse.
//     - Instantiated WIDTH times via generate.
//  - Top level: bus decode, pending/enable registers, irq reduction.
// TESTING (bench uses WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
//  - Reset: with reset=0, read every register -> all 0 and irq=0.
//     - Release reset with pins=4'b1111 -> STATE stays 0.
//  - Clean press: drive pin0=0 and hold.
//     - STATE=0x1 exactly 6 clocks later.
//     - RISE=0x1 on the same edge; irq stays 0 while IRQ_EN=0.
//  - Bounce: toggle pin1 low for 3 clocks, then high, repeated 5 times -> STATE[1], RISE[1] and FALL[1] stay 0.
//  - IRQ path:
//     - Write IRQ_EN=0x0001_0001, press and then release pin0 -> irq=1 after the press.
//     - Write RISE=0x1 -> RISE cleared, but irq stays 1 because FALL[0] is set.
//     - Write FALL=0x1 -> irq=0.
//  - Set/clear collision: W1C write to RISE[2] on the exact edge a press on pin2 is accepted -> RISE[2] reads 1.
//  - Reset mid-debounce: assert reset 2 clocks into a pin3 press, then release with the pin still low.
//     - STATE[3]=1 and RISE[3]=1 exactly 6 clocks after reset release; no earlier.

Source files
------------

// File: rtl/button_inputs_pkg.sv
// Shared definitions for the button input peripheral: register offsets and field bases.
package button_inputs_pkg;

  typedef enum logic [1:0] {
    BTN_STATE  = 2'd0,
    BTN_RISE   = 2'd1,
    BTN_FALL   = 2'd2,
    BTN_IRQ_EN = 2'd3
  } btn_reg_e;

  localparam int unsigned IRQ_EN_FALL_BASE = 16;
  localparam int unsigned BUS_WIDTH        = 32;

endpackage

// File: rtl/button_inputs_if.sv
// Simple zero-wait-state peripheral bus: single-cycle read/write strobes, combinational response.
interface button_inputs_if;
  import button_inputs_pkg::*;

  logic                 read;
  logic                 write;
  logic [BUS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0] write_data;
  logic [BUS_WIDTH-1:0] read_data;
  logic                 response;

  modport master (
    output read, write, address, write_data,
    input  read_data, response
  );

  modport slave (
    input  read, write, address, write_data,
    output read_data, response
  );

endinterface

// File: rtl/button_debounce.sv
// One button bit: 2-FF synchroniser, stability counter and accepted level with edge pulses.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntTerm = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            differ, accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], din};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // The counter restarts on any agreeing sample and on acceptance, so it never wraps.
  always_comb begin
    differ   = sync_q[1] ^ stable_q;
    accept   = differ && (cnt_q == CntTerm);
    cnt_d    = (!differ || accept) ? '0 : cnt_q + CntW'(1);
    stable_d = accept ? sync_q[1] : stable_q;
  end

  assign stable     = stable_q;
  assign rise_pulse = accept & sync_q[1];
  assign fall_pulse = accept & ~sync_q[1];

endmodule

// File: rtl/button_inputs.sv
// Memory-mapped debounced button port: level, W1C rise/fall pending, IRQ enables, level irq.
module button_inputs
  import button_inputs_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  button_inputs_if.slave    bus,
  input  logic [WIDTH-1:0]  buttons_in,
  output logic              irq
);

  logic [WIDTH-1:0]     pin_level, stable, rise_pulse, fall_pulse;
  logic [WIDTH-1:0]     rise_q, rise_d, fall_q, fall_d;
  logic [WIDTH-1:0]     en_rise_q, en_rise_d, en_fall_q, en_fall_d;
  logic [WIDTH-1:0]     wd_low, wd_high;
  logic [BUS_WIDTH-1:0] rdata;
  btn_reg_e             sel;
  logic                 unused_bus;

  assign pin_level  = ACTIVE_LOW ? ~buttons_in : buttons_in;
  assign sel        = btn_reg_e'(bus.address[3:2]);
  assign wd_low     = bus.write_data[WIDTH-1:0];
  assign wd_high    = bus.write_data[IRQ_EN_FALL_BASE +: WIDTH];
  assign unused_bus = ^{bus.address[BUS_WIDTH-1:4], bus.address[1:0], bus.write_data};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .din        (pin_level[i]),
      .stable     (stable[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

  // New events are OR-ed in after the clear so a coincident set wins.
  always_comb begin
    rise_d    = rise_q;
    fall_d    = fall_q;
    en_rise_d = en_rise_q;
    en_fall_d = en_fall_q;
    if (bus.write) begin
      unique case (sel)
        BTN_RISE:   rise_d = rise_q & ~wd_low;
        BTN_FALL:   fall_d = fall_q & ~wd_low;
        BTN_IRQ_EN: begin
          en_rise_d = wd_low;
          en_fall_d = wd_high;
        end
        default: ;
      endcase
    end
    rise_d = rise_d | rise_pulse;
    fall_d = fall_d | fall_pulse;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_q    <= '0;
      fall_q    <= '0;
      en_rise_q <= '0;
      en_fall_q <= '0;
    end else begin
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      en_rise_q <= en_rise_d;
      en_fall_q <= en_fall_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.read) begin
      unique case (sel)
        BTN_STATE:  rdata[WIDTH-1:0] = stable;
        BTN_RISE:   rdata[WIDTH-1:0] = rise_q;
        BTN_FALL:   rdata[WIDTH-1:0] = fall_q;
        BTN_IRQ_EN: begin
          rdata[WIDTH-1:0]                  = en_rise_q;
          rdata[IRQ_EN_FALL_BASE +: WIDTH]  = en_fall_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.read_data = rdata;
  assign bus.response  = bus.read | bus.write;
  assign irq           = (|(rise_q & en_rise_q)) | (|(fall_q & en_fall_q));

endmodule
